// File: rtl/timer_sequencer.sv
// timer_sequencer: programmable limit, counter, terminal detect and
// registered one-cycle tick with one-shot/periodic, hold and config handshake.
// Optional tick_total counter enabled by defining TIMER_SEQ_TICK_CNT_EN.
module timer_sequencer #(
    parameter int WIDTH         = 8,
    parameter int DEFAULT_LIMIT = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             cfg_periodic,
    output logic             cfg_ready,
    input  logic             start,
    input  logic             stop,
    input  logic             hold,
    output logic [WIDTH-1:0] count,
`ifdef TIMER_SEQ_TICK_CNT_EN
    output logic [15:0]      tick_total,
`endif
    output logic             tick,
    output logic             busy,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HOLD = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
    localparam logic [WIDTH-1:0] DEF = WIDTH'(DEFAULT_LIMIT);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] count_n;
    logic             tick_n;
    logic [WIDTH-1:0] limit_r;
    logic [WIDTH-1:0] limit_n;
    logic             periodic_r;
    logic             periodic_n;
    logic             cfg_acc;
    logic             terminal;

    assign cfg_ready = (state == IDLE) || (state == DONE);
    assign busy      = (state == RUN) || (state == HOLD);
    assign done      = (state == DONE);
    assign cfg_acc   = cfg_valid && cfg_ready;
    assign terminal  = (count == limit_r - ONE);

    // Next-state, counter and config update; HOLD with hold low counts like RUN
    // so each held cycle delays the tick by exactly one cycle.
    always_comb begin
        state_n    = state;
        count_n    = count;
        tick_n     = 1'b0;
        limit_n    = limit_r;
        periodic_n = periodic_r;
        if (cfg_acc) begin
            limit_n    = (cfg_limit == '0) ? ONE : cfg_limit;
            periodic_n = cfg_periodic;
        end
        if (stop) begin
            state_n = IDLE;
            count_n = '0;
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state_n = RUN;
                        count_n = '0;
                    end else if (cfg_acc) begin
                        state_n = IDLE;
                    end
                end
                RUN, HOLD: begin
                    if (hold) begin
                        state_n = HOLD;
                    end else if (terminal) begin
                        count_n = '0;
                        tick_n  = 1'b1;
                        state_n = periodic_r ? RUN : DONE;
                    end else begin
                        count_n = count + ONE;
                        state_n = RUN;
                    end
                end
                default: begin
                    state_n = IDLE;
                    count_n = '0;
                end
            endcase
        end
    end

    // State, counter, tick and configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            tick       <= 1'b0;
            limit_r    <= DEF;
            periodic_r <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            tick       <= tick_n;
            limit_r    <= limit_n;
            periodic_r <= periodic_n;
        end
    end

`ifdef TIMER_SEQ_TICK_CNT_EN
    // Running tick count; survives stop/start, cleared by a new config.
    always_ff @(posedge clk) begin
        if (rst || cfg_acc) begin
            tick_total <= '0;
        end else if (tick_n) begin
            tick_total <= tick_total + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_timer_sequencer.sv
// tb_timer_sequencer: directed self-checking bench for timer_sequencer.
// Exercises tick_total when TIMER_SEQ_TICK_CNT_EN is defined.
module tb_timer_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_valid;
    logic [7:0] cfg_limit;
    logic       cfg_periodic;
    logic       cfg_ready;
    logic       start;
    logic       stop;
    logic       hold;
    logic [7:0] count;
    logic       tick;
    logic       busy;
    logic       done;
`ifdef TIMER_SEQ_TICK_CNT_EN
    logic [15:0] tick_total;
`endif

    int tests = 0;
    int fails = 0;

    timer_sequencer #(.WIDTH(8), .DEFAULT_LIMIT(10)) dut (
        .clk(clk),
        .rst(rst),
        .cfg_valid(cfg_valid),
        .cfg_limit(cfg_limit),
        .cfg_periodic(cfg_periodic),
        .cfg_ready(cfg_ready),
        .start(start),
        .stop(stop),
        .hold(hold),
        .count(count),
`ifdef TIMER_SEQ_TICK_CNT_EN
        .tick_total(tick_total),
`endif
        .tick(tick),
        .busy(busy),
        .done(done)
    );

    always #5 clk = ~clk;

    // One rising edge, then settle at the falling edge for sampling.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        tests++;
        if (count !== 8'd0 || tick !== 1'b0) begin
            fails++;
            $display("FAIL reset_cnt count=%0d tick=%b want 0 0", count, tick);
        end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_st busy=%b done=%b rdy=%b want 0 0 1",
                     busy, done, cfg_ready);
        end
    endtask

    task automatic test_oneshot();
        start = 1'b1;
        cyc();
        start = 1'b0;
        tests++;
        if (count !== 8'd0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL os_start count=%0d busy=%b want 0 1", count, busy);
        end
        for (int i = 1; i <= 9; i++) begin
            cyc();
            tests++;
            if (count !== 8'(i) || tick !== 1'b0) begin
                fails++;
                $display("FAIL os_count%0d count=%0d tick=%b want %0d 0",
                         i, count, tick, i);
            end
        end
        cyc();
        tests++;
        if (tick !== 1'b1 || done !== 1'b1 || busy !== 1'b0 || count !== 8'd0) begin
            fails++;
            $display("FAIL os_term tick=%b done=%b busy=%b count=%0d want 1 1 0 0",
                     tick, done, busy, count);
        end
        cyc();
        tests++;
        if (tick !== 1'b0 || done !== 1'b1) begin
            fails++;
            $display("FAIL os_after tick=%b done=%b want 0 1", tick, done);
        end
    endtask

    task automatic test_periodic();
        cfg_valid    = 1'b1;
        cfg_limit    = 8'd4;
        cfg_periodic = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        tests++;
        if (done !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL per_cfg done=%b rdy=%b want 0 1", done, cfg_ready);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            tests++;
            if (tick !== ((k % 4) == 0) || count !== 8'(k % 4) ||
                busy !== 1'b1 || cfg_ready !== 1'b0) begin
                fails++;
                $display("FAIL per_k%0d tick=%b count=%0d busy=%b rdy=%b want %b %0d 1 0",
                         k, tick, count, busy, cfg_ready, (k % 4) == 0, k % 4);
            end
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        tests++;
        if (busy !== 1'b0 || count !== 8'd0 || tick !== 1'b0) begin
            fails++;
            $display("FAIL per_stop busy=%b count=%0d tick=%b want 0 0 0",
                     busy, count, tick);
        end
    endtask

    task automatic test_hold();
        cfg_valid    = 1'b1;
        cfg_limit    = 8'd5;
        cfg_periodic = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        cyc();
        cyc();
        tests++;
        if (count !== 8'd2) begin
            fails++;
            $display("FAIL hold_pre count=%0d want 2", count);
        end
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests++;
            if (count !== 8'd2 || tick !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL hold_frz%0d count=%0d tick=%b busy=%b want 2 0 1",
                         i, count, tick, busy);
            end
        end
        hold = 1'b0;
        cyc();
        tests++;
        if (count !== 8'd3 || tick !== 1'b0) begin
            fails++;
            $display("FAIL hold_c3 count=%0d tick=%b want 3 0", count, tick);
        end
        cyc();
        tests++;
        if (count !== 8'd4 || tick !== 1'b0) begin
            fails++;
            $display("FAIL hold_c4 count=%0d tick=%b want 4 0", count, tick);
        end
        cyc();
        tests++;
        if (count !== 8'd0 || tick !== 1'b1 || busy !== 1'b1) begin
            fails++;
            $display("FAIL hold_tick count=%0d tick=%b busy=%b want 0 1 1",
                     count, tick, busy);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic test_stop_start();
        cfg_valid    = 1'b1;
        cfg_limit    = 8'd10;
        cfg_periodic = 1'b0;
        cyc();
        cfg_valid = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (3) cyc();
        tests++;
        if (count !== 8'd3) begin
            fails++;
            $display("FAIL ss_pre count=%0d want 3", count);
        end
        stop      = 1'b1;
        start     = 1'b1;
        cfg_valid = 1'b1;
        cfg_limit = 8'd2;
        #1;
        tests++;
        if (cfg_ready !== 1'b0) begin
            fails++;
            $display("FAIL ss_rdy rdy=%b want 0", cfg_ready);
        end
        cyc();
        stop      = 1'b0;
        start     = 1'b0;
        cfg_valid = 1'b0;
        tests++;
        if (busy !== 1'b0 || count !== 8'd0 || tick !== 1'b0 || done !== 1'b0) begin
            fails++;
            $display("FAIL ss_idle busy=%b count=%0d tick=%b done=%b want 0 0 0 0",
                     busy, count, tick, done);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (9) cyc();
        tests++;
        if (count !== 8'd9 || tick !== 1'b0) begin
            fails++;
            $display("FAIL ss_lim count=%0d tick=%b want 9 0", count, tick);
        end
        stop = 1'b1;
        cyc();
        stop = 1'b0;
    endtask

    task automatic test_limit_zero();
        cfg_valid    = 1'b1;
        cfg_limit    = 8'd0;
        cfg_periodic = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        tests++;
        if (count !== 8'd0 || tick !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL lz_start count=%0d tick=%b busy=%b want 0 0 1",
                     count, tick, busy);
        end
        for (int i = 0; i < 3; i++) begin
            cyc();
            tests++;
            if (count !== 8'd0 || tick !== 1'b1) begin
                fails++;
                $display("FAIL lz_tick%0d count=%0d tick=%b want 0 1", i, count, tick);
            end
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        tests++;
        if (busy !== 1'b0 || count !== 8'd0 || tick !== 1'b0 || cfg_ready !== 1'b1) begin
            fails++;
            $display("FAIL lz_rst busy=%b count=%0d tick=%b rdy=%b want 0 0 0 1",
                     busy, count, tick, cfg_ready);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (9) cyc();
        tests++;
        if (tick !== 1'b0 || count !== 8'd9) begin
            fails++;
            $display("FAIL lz_def9 count=%0d tick=%b want 9 0", count, tick);
        end
        cyc();
        tests++;
        if (tick !== 1'b1 || done !== 1'b1) begin
            fails++;
            $display("FAIL lz_def10 tick=%b done=%b want 1 1", tick, done);
        end
    endtask

    task automatic test_back_to_back();
        cfg_valid    = 1'b1;
        cfg_limit    = 8'd3;
        cfg_periodic = 1'b0;
        start        = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        start     = 1'b0;
        tests++;
        if (busy !== 1'b1 || count !== 8'd0 || done !== 1'b0) begin
            fails++;
            $display("FAIL b2b_start busy=%b count=%0d done=%b want 1 0 0",
                     busy, count, done);
        end
        cyc();
        cyc();
        tests++;
        if (count !== 8'd2 || tick !== 1'b0) begin
            fails++;
            $display("FAIL b2b_c2 count=%0d tick=%b want 2 0", count, tick);
        end
        cyc();
        tests++;
        if (tick !== 1'b1 || done !== 1'b1 || count !== 8'd0) begin
            fails++;
            $display("FAIL b2b_term tick=%b done=%b count=%0d want 1 1 0",
                     tick, done, count);
        end
    endtask

`ifdef TIMER_SEQ_TICK_CNT_EN
    task automatic test_tick_total();
        cfg_valid    = 1'b1;
        cfg_limit    = 8'd1;
        cfg_periodic = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        tests++;
        if (tick_total !== 16'd0) begin
            fails++;
            $display("FAIL tt_clr tick_total=%0d want 0", tick_total);
        end
        start = 1'b1;
        cyc();
        start = 1'b0;
        repeat (70000) cyc();
        tests++;
        if (tick_total !== 16'd4464) begin
            fails++;
            $display("FAIL tt_wrap tick_total=%0d want 4464", tick_total);
        end
        stop = 1'b1;
        cyc();
        stop  = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        tests++;
        if (tick_total !== 16'd4464) begin
            fails++;
            $display("FAIL tt_keep tick_total=%0d want 4464", tick_total);
        end
        stop = 1'b1;
        cyc();
        stop      = 1'b0;
        cfg_valid = 1'b1;
        cyc();
        cfg_valid = 1'b0;
        tests++;
        if (tick_total !== 16'd0) begin
            fails++;
            $display("FAIL tt_cfg tick_total=%0d want 0", tick_total);
        end
    endtask
`endif

    initial begin
        rst          = 1'b1;
        cfg_valid    = 1'b0;
        cfg_limit    = 8'd0;
        cfg_periodic = 1'b0;
        start        = 1'b0;
        stop         = 1'b0;
        hold         = 1'b0;
        cyc();
        test_reset();
        test_oneshot();
        test_periodic();
        test_hold();
        test_stop_start();
        test_limit_zero();
        test_back_to_back();
`ifdef TIMER_SEQ_TICK_CNT_EN
        test_tick_total();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/timer_sequencer.md
Name: timer_sequencer

Overview:
- Controller that sequences a count/compare/register tick datapath: holds a programmable limit, runs the counter, detects the terminal count and emits a registered one-cycle tick.
- Supports one-shot and periodic modes, hold (pause) control, and a valid/ready configuration handshake.
- Sits between a control source (CPU-style register interface or top-level FSM) and downstream logic that consumes periodic ticks.

Parameters:
- WIDTH, 8, bit width of limit and counter.
- DEFAULT_LIMIT, 10, limit loaded at reset; must be in range 1 to 2^WIDTH-1.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_valid  input  1  configuration request.
- cfg_limit  input  WIDTH  new terminal limit (tick period in cycles).
- cfg_periodic  input  1  1 = periodic, 0 = one-shot.
- cfg_ready  output  1  configuration accepted when cfg_valid && cfg_ready.
- start  input  1  pulse; begins counting.
- stop  input  1  pulse; aborts to IDLE.
- hold  input  1  level; freezes counting while high.
- count  output  WIDTH  current counter value.
- tick  output  1  registered one-cycle pulse at terminal count.
- busy  output  1  high in RUN or HOLD.
- done  output  1  high in DONE (one-shot completed).

Behaviour:
- Reset (synchronous, active-high, on clk edge with rst=1):
  - state=IDLE, count=0, tick=0, limit_r=DEFAULT_LIMIT, periodic_r=0.
  - Outputs: busy=0, done=0, cfg_ready=1.
- States: IDLE, RUN, HOLD, DONE.
- cfg_ready is combinational: 1 in IDLE or DONE, 0 in RUN or HOLD.
- Config handshake:
  - On cfg_valid && cfg_ready, load limit_r and periodic_r on the next edge.
  - cfg_limit=0 is stored as 1.
  - Config accepted in DONE moves the block to IDLE.
- Transitions, in priority order (stop > start > hold > terminal):
  - stop=1 in any state: next state IDLE, count<=0, tick<=0.
  - IDLE/DONE with start=1: next state RUN, count<=0. If config and start occur in the same cycle, the new limit applies to this run.
  - start while in RUN or HOLD is ignored.
  - RUN with hold=1: next state HOLD; count does not advance that cycle.
  - HOLD: count frozen, no tick. hold=0 returns to RUN on the next edge.
  - RUN with hold=0 and count != limit_r-1: count<=count+1.
  - RUN with hold=0 and count == limit_r-1 (terminal):
    - count<=0 and tick<=1 on the same edge.
    - periodic_r=1: remain in RUN.
    - periodic_r=0: next state DONE.
- Tick timing and latency:
  - tick is high for exactly one cycle, in the cycle after the terminal value is present on count.
  - Periodic tick period is exactly limit_r cycles while not held; each held cycle extends the period by one.
  - First tick arrives limit_r cycles after the start edge.
  - limit_r=1: tick every cycle in periodic mode.
- Arithmetic: count is an unsigned WIDTH-bit value that never exceeds limit_r-1, so no overflow wrap occurs.
- done stays high in DONE until start, stop, or an accepted config.
- rst asserted mid-run: next edge returns all registers to reset values, and the configured limit is lost.

Optional Feature:
- Macro TIMER_SEQ_TICK_CNT_EN.
- Defined:
  - Adds output tick_total (16 bits), incremented on every tick and wrapping from 65535 to 0.
  - Cleared by rst or an accepted config; not cleared by stop or start.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset then start, default limit 10, periodic=0 -> count 0..9; tick high one cycle 10 cycles after start; then done=1, busy=0, count=0.
- Config limit=4 periodic=1, then start -> tick on cycles 4, 8, 12 after start; busy stays 1; cfg_ready=0 throughout.
- Periodic limit=5, hold high for 3 cycles at count=2 -> count frozen at 2, no tick; tick arrives 3 cycles later than without hold.
- stop and start asserted in the same cycle during RUN at count=3 -> IDLE, count=0, no tick; a cfg_valid during RUN is not accepted (cfg_ready=0).
- Config limit=0 -> stored as 1; periodic start gives tick every cycle; rst mid-run -> limit_r=10, count=0, state IDLE next cycle.
- With TIMER_SEQ_TICK_CNT_EN defined, limit=1 periodic for 70000 cycles -> tick_total wraps to 4464; stop/start preserves it; a new config clears it to 0.
